gamepad_event_scheduler: RTL



---
 rtl/gamepad_event_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gamepad_event_scheduler.sv
// gamepad_event_scheduler: button edges and auto-repeat -> round-robin -> event FIFO
// Auto-repeat tracker is built only when GAMEPAD_AUTOREPEAT_EN is defined.
module gamepad_event_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   buttons,
  input  logic          present,
  input  logic          frame_tick,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [3:0]    evt_id,
  output logic          evt_repeat,
  output logic [CW-1:0] evt_count
);

  logic [11:0]   btn_q;
  logic [11:0]   btn_prev;
  logic [11:0]   rise;
  logic [11:0]   pend;
  logic [11:0]   pend_rep;
  logic [11:0]   fire_vec;
  logic [11:0]   set_vec;
  logic [11:0]   gnt_vec;
  logic [11:0]   rep_nxt;
  logic [3:0]    last_grant;
  logic [3:0]    gnt_idx;
  logic          gnt_found;
  logic          push;
  logic          pop;
  logic          full;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [4:0]    head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [3:0] rr_idx(
    input logic [3:0] base,
    input int         k
  );
    logic [4:0] s;
    s = {1'b0, base} + 5'(k);
    if (s >= 5'd12) s = s - 5'd12;
    return s[3:0];
  endfunction

  assign rise    = btn_q & ~btn_prev;
  assign set_vec = rise | fire_vec;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push    = gnt_found & ~full;
  assign pop     = evt_valid & evt_ready;
  assign gnt_vec = push ? (12'b1 << gnt_idx) : '0;

  // a repeat only marks the entry as repeat if nothing was already pending
  assign rep_nxt = (pend_rep & ~rise & ~(fire_vec & ~pend))
                 | (fire_vec & ~pend & ~rise);

  assign head       = mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign evt_id     = head[3:0];
  assign evt_count  = count;

  // sample buttons, forcing all released while no controller is attached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q    <= '0;
      btn_prev <= '0;
    end else begin
      btn_q    <= present ? buttons : '0;
      btn_prev <= btn_q;
    end
  end

  // pending events: a new set beats a grant clear on the same bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      pend_rep <= '0;
    end else if (!present) begin
      pend     <= '0;
      pend_rep <= '0;
    end else begin
      pend     <= (pend & ~gnt_vec) | set_vec;
      pend_rep <= rep_nxt;
    end
  end

  // round-robin search starting just after the last granted button
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= 12; k++) begin
      if (!gnt_found && pend[rr_idx(last_grant, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(last_grant, k);
      end
    end
  end

  // remember the winner so the next search starts past it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant <= 4'd11;
    else if (push) last_grant <= gnt_idx;
  end

  // event FIFO with wrapping pointers and an occupancy counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {pend_rep[gnt_idx], gnt_idx};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef GAMEPAD_AUTOREPEAT_EN
  logic [3:0] rep_btn;
  logic [3:0] rise_hi;
  logic [7:0] rep_timer;
  logic       rep_act;
  logic       rep_fire;

  // highest-numbered button among this cycle's rises
  always_comb begin
    rise_hi = '0;
    for (int i = 0; i < 12; i++) begin
      if (rise[i]) rise_hi = 4'(i);
    end
  end

  assign rep_fire = present & ~(|rise) & rep_act
                  & btn_q[rep_btn] & frame_tick
                  & (rep_timer == 8'd1);
  assign fire_vec = rep_fire ? (12'b1 << rep_btn) : '0;
  assign evt_repeat = head[4];

  // single shared timer following the most recently pressed button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_btn   <= '0;
      rep_timer <= '0;
      rep_act   <= 1'b0;
    end else if (!present) begin
      rep_act <= 1'b0;
    end else if (|rise) begin
      rep_btn   <= rise_hi;
      rep_timer <= 8'(REPEAT_DELAY);
      rep_act   <= 1'b1;
    end else if (rep_act && !btn_q[rep_btn]) begin
      rep_act <= 1'b0;
    end else if (rep_act && frame_tick) begin
      if (rep_timer == 8'd1) rep_timer <= 8'(REPEAT_RATE);
      else rep_timer <= rep_timer - 8'd1;
    end
  end
`else
  logic unused_ok;

  assign fire_vec   = '0;
  assign evt_repeat = 1'b0;
  assign unused_ok  = ^{frame_tick, head[4],
                        8'(REPEAT_DELAY), 8'(REPEAT_RATE)};
`endif

endmodule
